// File: rtl/input_debouncer.sv
// Board input conditioner for DE1-SoC KEY/SW lines: 2-FF sync, counter debounce,
// key inversion and one-cycle press/release pulses on the debounced keys.
module input_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_KEYS-1:0] key_n_in,
    input  logic [N_SW-1:0]   sw_in,
    output logic [N_KEYS-1:0] pushbuttons_export,
    output logic [N_SW-1:0]   slider_switches_export,
    output logic [N_KEYS-1:0] key_press_pulse,
    output logic [N_KEYS-1:0] key_release_pulse
);

    localparam int NB = N_KEYS + N_SW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Keys are active-low: their sync flops idle at 1 and are flipped after sync.
    localparam logic [NB-1:0] KEY_MASK = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

    logic [NB-1:0]            s1;
    logic [NB-1:0]            s2;
    logic [NB-1:0]            sample;
    logic [NB-1:0]            stable;
    logic [NB-1:0]            diff;
    logic [NB-1:0]            fire;
    logic [NB-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1 <= KEY_MASK;
            s2 <= KEY_MASK;
        end else begin
            s1 <= {sw_in, key_n_in};
            s2 <= s1;
        end
    end

    assign sample = s2 ^ KEY_MASK;
    assign diff   = sample ^ stable;

    always_comb begin
        fire = '0;
        for (int i = 0; i < NB; i++) begin
            fire[i] = diff[i] && (cnt[i] == CNT_LAST);
        end
    end

    // Any agreement with the stable level, or a completed run, restarts the count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!diff[i] || fire[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable            <= '0;
            key_press_pulse   <= '0;
            key_release_pulse <= '0;
        end else begin
            stable            <= stable ^ fire;
            key_press_pulse   <= fire[N_KEYS-1:0] & sample[N_KEYS-1:0];
            key_release_pulse <= fire[N_KEYS-1:0] & ~sample[N_KEYS-1:0];
        end
    end

    assign pushbuttons_export     = stable[N_KEYS-1:0];
    assign slider_switches_export = stable[NB-1:N_KEYS];

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized bench for input_debouncer with an in-bench sample-history model
// and directed scenarios pinning latency, bounce, release and reset behaviour.
module tb_input_debouncer;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int NB = NK + NS;
    localparam int D  = 8;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NS-1:0] sw;
    logic [NK-1:0] pb;
    logic [NS-1:0] sws;
    logic [NK-1:0] press;
    logic [NK-1:0] release_p;

    int checks   = 0;
    int failures = 0;

    input_debouncer #(
        .N_KEYS(NK),
        .N_SW(NS),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .key_n_in(key_n),
        .sw_in(sw),
        .pushbuttons_export(pb),
        .slider_switches_export(sws),
        .key_press_pulse(press),
        .key_release_pulse(release_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    // Model: history of active-high input levels per bit since reset.
    // The two leading entries are the levels the sync stages hold at reset.
    // The level flips when the D samples reaching the counter at the last
    // D edges all disagree with it, none older than the previous flip.
    int mq[NB][$];
    int last_flip[NB];
    bit m_st[NB];
    bit m_pr[NB];
    bit m_rl[NB];

    function automatic bit level(int b);
        if (b < NK) return ~key_n[b];
        return sw[b-NK];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            mq[b].delete();
            mq[b].push_back(0);
            mq[b].push_back(0);
            last_flip[b] = -1;
            m_st[b] = 0;
            m_pr[b] = 0;
            m_rl[b] = 0;
        end
    endtask

    task automatic model_step();
        for (int b = 0; b < NB; b++) begin
            int n;
            int lo;
            int hi;
            bit all_diff;
            m_pr[b] = 0;
            m_rl[b] = 0;
            mq[b].push_back(int'(level(b)));
            n  = mq[b].size();
            hi = n - 3;
            lo = n - D - 2;
            if (lo >= 0 && lo > last_flip[b]) begin
                all_diff = 1;
                for (int j = lo; j <= hi; j++) begin
                    if (mq[b][j] == int'(m_st[b])) all_diff = 0;
                end
                if (all_diff) begin
                    m_st[b] = ~m_st[b];
                    last_flip[b] = hi;
                    if (b < NK) begin
                        if (m_st[b]) m_pr[b] = 1;
                        else m_rl[b] = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic [NK-1:0] e_pb;
        logic [NK-1:0] e_pr;
        logic [NK-1:0] e_rl;
        logic [NS-1:0] e_sw;
        #1;
        if (rst_n === 1'b1) model_step();
        for (int b = 0; b < NK; b++) begin
            e_pb[b] = m_st[b];
            e_pr[b] = m_pr[b];
            e_rl[b] = m_rl[b];
        end
        for (int b = 0; b < NS; b++) e_sw[b] = m_st[NK+b];
        chk("model_pb", 32'(pb), 32'(e_pb));
        chk("model_sw", 32'(sws), 32'(e_sw));
        chk("model_press", 32'(press), 32'(e_pr));
        chk("model_release", 32'(release_p), 32'(e_rl));
        chk("pulse_overlap", 32'(press & release_p), 32'd0);
    end

    initial begin
        key_n = 4'hF;
        sw    = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (20) @(negedge clk);
        chk("t1_pb", 32'(pb), 32'd0);
        chk("t1_sw", 32'(sws), 32'd0);
        chk("t1_pulses", 32'({press, release_p}), 32'd0);

        // key 0 press: output and pulse after edge 10
        key_n[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("t2_pb_e9", 32'(pb), 32'd0);
        @(negedge clk);
        chk("t2_pb_e10", 32'(pb), 32'h1);
        chk("t2_press_e10", 32'(press), 32'h1);
        @(negedge clk);
        chk("t2_press_e11", 32'(press), 32'h0);
        chk("t2_pb_e11", 32'(pb), 32'h1);

        // key 1 bounce of 5 cycles
        key_n[1] = 1'b0;
        repeat (5) @(negedge clk);
        key_n[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t3_pb", 32'(pb), 32'h1);
            chk("t3_pulses", 32'({press, release_p}), 32'd0);
        end

        // key 0 release
        key_n[0] = 1'b1;
        repeat (9) @(negedge clk);
        chk("t4_pb_e9", 32'(pb), 32'h1);
        chk("t4_rel_e9", 32'(release_p), 32'h0);
        @(negedge clk);
        chk("t4_pb_e10", 32'(pb), 32'h0);
        chk("t4_rel_e10", 32'(release_p), 32'h1);
        chk("t4_press_e10", 32'(press), 32'h0);
        @(negedge clk);
        chk("t4_rel_e11", 32'(release_p), 32'h0);

        // switches held high through reset
        sw = 10'h3FF;
        repeat (12) @(negedge clk);
        chk("t5_sw_pre", 32'(sws), 32'h3FF);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_sw_in_reset", 32'(sws), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("t5_sw_e9", 32'(sws), 32'h0);
        @(negedge clk);
        chk("t5_sw_e10", 32'(sws), 32'h3FF);
        chk("t5_pulses", 32'({press, release_p}), 32'd0);

        // reset at count 5 of a key 2 press
        key_n[2] = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_sw_rst", 32'(sws), 32'h0);
        chk("t6_pb_rst", 32'(pb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("t6_pb_e9", 32'(pb), 32'h0);
        @(negedge clk);
        chk("t6_pb_e10", 32'(pb), 32'h4);
        chk("t6_press_e10", 32'(press), 32'h4);
        chk("t6_sw_e10", 32'(sws), 32'h3FF);

        // random toggling with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst_n == 1'b0) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            for (int b = 0; b < NK; b++) begin
                if ($urandom_range(0, 9) == 0) key_n[b] = ~key_n[b];
            end
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 13) == 0) sw[b] = ~sw[b];
            end
        end
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
